// File: rtl/data_mem_port_pkg.sv
// Shared types, encodings and helpers for the data memory port.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// Holds the XLEN and write-length defines used across the codebase (added
// here when absent), plus lane-mask and misalignment helpers.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef LEN_B
`define LEN_B 2'd0
`endif
`ifndef LEN_H
`define LEN_H 2'd1
`endif
`ifndef LEN_W
`define LEN_W 2'd2
`endif

package data_mem_port_pkg;

    localparam int XLEN = `XLEN;

    typedef enum logic [1:0] {
        LEN_BYTE = `LEN_B,
        LEN_HALF = `LEN_H,
        LEN_WORD = `LEN_W,
        LEN_RSVD = 2'd3
    } len_e;

    // Byte lanes touched by a store of the given size at byte offset off.
    function automatic logic [3:0] lane_mask(len_e len, logic [1:0] off);
        case (len)
            LEN_BYTE: lane_mask = 4'b0001 << off;
            LEN_HALF: lane_mask = 4'b0011 << {off[1], 1'b0};
            LEN_WORD: lane_mask = 4'b1111;
            default:  lane_mask = 4'b0000;
        endcase
    endfunction

    // A store is rejected if it straddles its natural alignment or uses
    // the reserved size encoding.
    function automatic logic is_misaligned(len_e len, logic [1:0] off);
        case (len)
            LEN_HALF: is_misaligned = off[0];
            LEN_WORD: is_misaligned = (off != 2'b00);
            LEN_RSVD: is_misaligned = 1'b1;
            default:  is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_port_if.sv
// Bus bundle between a load/store unit and the data memory port.
// Latency: n/a (wiring only).
// Backpressure: none; the port accepts one read and one write every cycle.
// master drives read/write requests; slave returns read data and the
// sticky misaligned flag.

interface data_mem_port_if;
    import data_mem_port_pkg::*;

    logic [XLEN-1:0] i_addr_r;
    logic [XLEN-1:0] o_data_r;
    logic [XLEN-1:0] i_addr_w;
    logic [XLEN-1:0] i_data_w;
    logic [1:0]      i_len_w;
    logic            i_write_en;
    logic            o_misaligned;

    modport master (
        output i_addr_r,
        output i_addr_w,
        output i_data_w,
        output i_len_w,
        output i_write_en,
        input  o_data_r,
        input  o_misaligned
    );

    modport slave (
        input  i_addr_r,
        input  i_addr_w,
        input  i_data_w,
        input  i_len_w,
        input  i_write_en,
        output o_data_r,
        output o_misaligned
    );

endinterface

// File: rtl/data_mem_port_bank.sv
// Word-wide synchronous RAM with per-byte write enables, read-first.
// Latency: read data registered one edge after raddr is presented.
// Backpressure: none; one read and one write accepted every cycle.
// Ports: clk, we[3:0] byte-lane enables, waddr/wdata write word,
// raddr read word index, rdata registered read word (old data on collision).

module dmem_bank #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // No reset on the array or read register so the RAM maps to block RAM.
    // The non-blocking read of mem gives read-first behaviour on collision.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/data_mem_port.sv
// Data memory port: byte/half/word stores, right-justified word loads.
// Latency: read address in cycle N -> o_data_r valid in cycle N+2; stores commit at end of cycle.
// Backpressure: none; one read and one write every cycle, misaligned stores dropped and flagged.
// Ports: clk, rstn (sync, active-low), bus (slave modport: i_addr_r, o_data_r,
// i_addr_w, i_data_w, i_len_w, i_write_en, o_misaligned).

module data_mem_port
    import data_mem_port_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            rstn,
    data_mem_port_if.slave  bus
);

    logic [XLEN-1:0] addr_a_q;
    logic            vld_a_q;
    logic            vld_b_q;
    logic [1:0]      off_b_q;
    logic            mis_q;
    logic [31:0]     rd_word;

    logic [1:0]      w_off;
    logic            w_bad;
    logic [3:0]      bank_we;
    logic [31:0]     w_shifted;

    // Upper address bits alias onto the same words.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{addr_a_q[XLEN-1:AW+2], bus.i_addr_w[XLEN-1:AW+2]};

    // Write lane decode and placement.
    always_comb begin
        w_off     = bus.i_addr_w[1:0];
        w_bad     = is_misaligned(len_e'(bus.i_len_w), w_off);
        w_shifted = bus.i_data_w << {w_off, 3'b000};
        bank_we   = 4'b0000;
        if (bus.i_write_en && rstn && !w_bad) begin
            bank_we = lane_mask(len_e'(bus.i_len_w), w_off);
        end
    end

    // Stage A: capture the read address.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_a_q <= '0;
            vld_a_q  <= 1'b0;
        end else begin
            addr_a_q <= bus.i_addr_r;
            vld_a_q  <= 1'b1;
        end
    end

    // Stage B: the bank registers the word; the byte offset and a valid bit
    // travel alongside so reads in flight at reset come out as zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_b_q <= 1'b0;
            off_b_q <= 2'b00;
        end else begin
            vld_b_q <= vld_a_q;
            off_b_q <= addr_a_q[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mis_q <= 1'b0;
        end else if (bus.i_write_en && w_bad) begin
            mis_q <= 1'b1;
        end
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .waddr (bus.i_addr_w[AW+1:2]),
        .wdata (w_shifted),
        .raddr (addr_a_q[AW+1:2]),
        .rdata (rd_word)
    );

    assign bus.o_data_r     = vld_b_q ? (rd_word >> {off_b_q, 3'b000}) : '0;
    assign bus.o_misaligned = mis_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Bench for data_mem_port: vector table plus hand sequences, read scoreboard.
// Latency: reads expected two edges after the address is driven.
// Backpressure: none exercised; the port never stalls.

module tb_data_mem_port;
    import data_mem_port_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    data_mem_port_if bus();

    data_mem_port #(.DEPTH_WORDS(4096)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    typedef struct {
        bit          rd;
        logic [31:0] raddr;
        logic [31:0] rexp;
        bit          we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [1:0]  len;
        logic        mis;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] exp;
        logic [31:0] addr;
    } sb_t;

    sb_t  sb[$];
    vec_t tbl[24];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2, RSV = 2'd3;

    function automatic vec_t mk(bit rd, logic [31:0] raddr, logic [31:0] rexp,
                                bit we, logic [31:0] waddr, logic [31:0] wdata,
                                logic [1:0] len, logic mis);
        vec_t v;
        v.rd = rd; v.raddr = raddr; v.rexp = rexp;
        v.we = we; v.waddr = waddr; v.wdata = wdata; v.len = len; v.mis = mis;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            sb_t e;
            e = sb.pop_front();
            chk($sformatf("read@%h", e.addr), bus.o_data_r, e.exp);
        end
    endtask

    task automatic drive(bit rd, logic [31:0] raddr, logic [31:0] rexp,
                         bit we, logic [31:0] waddr, logic [31:0] wdata, logic [1:0] len);
        sb_t e;
        bus.i_addr_r   = raddr;
        bus.i_write_en = we;
        bus.i_addr_w   = waddr;
        bus.i_data_w   = wdata;
        bus.i_len_w    = len;
        if (rd) begin
            e.due = cyc + 2; e.exp = rexp; e.addr = raddr;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        drive(0, 32'h0, 32'h0, 0, 32'h0, 32'h0, W);
    endtask

    task automatic flush();
        for (int k = 0; k < 8 && sb.size() != 0; k++) step();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL flush: %0d reads outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rd raddr          rexp           we waddr         wdata          len mis
        tbl[0]  = mk(0, 32'h0,        32'h0,         1, 32'h10,       32'hDEADBEEF,  W,  0);
        tbl[1]  = mk(1, 32'h10,       32'hDEADBEEF,  0, 32'h0,        32'h0,         W,  0);
        tbl[2]  = mk(0, 32'h0,        32'h0,         1, 32'h10,       32'h11223344,  W,  0);
        tbl[3]  = mk(0, 32'h0,        32'h0,         1, 32'h13,       32'h123456AA,  B,  0);
        tbl[4]  = mk(1, 32'h10,       32'hAA223344,  0, 32'h0,        32'h0,         W,  0);
        tbl[5]  = mk(1, 32'h13,       32'h000000AA,  0, 32'h0,        32'h0,         W,  0);
        tbl[6]  = mk(0, 32'h0,        32'h0,         1, 32'h20,       32'hCAFEF00D,  W,  0);
        tbl[7]  = mk(0, 32'h0,        32'h0,         1, 32'h21,       32'h00005566,  H,  1);
        tbl[8]  = mk(1, 32'h20,       32'hCAFEF00D,  0, 32'h0,        32'h0,         W,  1);
        tbl[9]  = mk(0, 32'h0,        32'h0,         1, 32'h0,        32'h01020304,  W,  1);
        tbl[10] = mk(0, 32'h0,        32'h0,         1, 32'h4,        32'h05060708,  W,  1);
        tbl[11] = mk(0, 32'h0,        32'h0,         1, 32'h8,        32'h090A0B0C,  W,  1);
        tbl[12] = mk(1, 32'h0,        32'h01020304,  0, 32'h0,        32'h0,         W,  1);
        tbl[13] = mk(1, 32'h4,        32'h05060708,  0, 32'h0,        32'h0,         W,  1);
        tbl[14] = mk(1, 32'h8,        32'h090A0B0C,  0, 32'h0,        32'h0,         W,  1);
        tbl[15] = mk(0, 32'h0,        32'h0,         1, 32'h0A,       32'hFFFFBEEF,  H,  1);
        tbl[16] = mk(0, 32'h0,        32'h0,         1, 32'h01,       32'hFFFFFF99,  B,  1);
        tbl[17] = mk(1, 32'h8,        32'hBEEF0B0C,  0, 32'h4,        32'hFFFFFFFF,  W,  1);
        tbl[18] = mk(1, 32'h1,        32'h00010299,  1, 32'h06,       32'h77777777,  W,  1);
        tbl[19] = mk(1, 32'h0A,       32'h0000BEEF,  1, 32'h10,       32'h00000000,  RSV, 1);
        tbl[20] = mk(1, 32'h4,        32'h05060708,  1, 32'h30,       32'h0BADC0DE,  W,  1);
        tbl[21] = mk(1, 32'h4010,     32'hAA223344,  0, 32'h0,        32'h0,         W,  1);
        tbl[22] = mk(1, 32'h2,        32'h00000102,  1, 32'h4024,     32'h13572468,  W,  1);
        tbl[23] = mk(1, 32'h24,       32'h13572468,  0, 32'h0,        32'h0,         W,  1);

        // Reset state.
        rstn = 1'b0;
        idle();
        step();
        step();
        chk("reset o_data_r", bus.o_data_r, 32'h0);
        chk("reset o_misaligned", {31'h0, bus.o_misaligned}, 32'h0);
        rstn = 1'b1;

        // Table: one row per cycle.
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].rd, tbl[i].raddr, tbl[i].rexp,
                  tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].len);
            step();
            chk($sformatf("row%0d o_misaligned", i), {31'h0, bus.o_misaligned}, {31'h0, tbl[i].mis});
        end
        idle();
        flush();

        // Load issued one cycle before a store to the same word sees the old value.
        drive(1, 32'h30, 32'h0BADC0DE, 0, 32'h0, 32'h0, W);
        step();
        drive(0, 32'h0, 32'h0, 1, 32'h30, 32'h12345678, W);
        step();
        idle();
        step();
        drive(1, 32'h30, 32'h12345678, 0, 32'h0, 32'h0, W);
        step();
        idle();
        flush();
        chk("sticky o_misaligned", {31'h0, bus.o_misaligned}, 32'h1);

        // One-cycle reset mid-stream, with a write strobe that must be ignored.
        drive(0, 32'h10, 32'h0, 0, 32'h0, 32'h0, W);
        step();
        drive(0, 32'h14, 32'h0, 1, 32'h10, 32'h00000000, W);
        rstn = 1'b0;
        step();
        chk("post-reset o_data_r", bus.o_data_r, 32'h0);
        chk("post-reset o_misaligned", {31'h0, bus.o_misaligned}, 32'h0);
        rstn = 1'b1;
        drive(1, 32'h10, 32'hAA223344, 0, 32'h0, 32'h0, W);
        step();
        drive(1, 32'h8, 32'hBEEF0B0C, 0, 32'h0, 32'h0, W);
        step();
        drive(1, 32'h20, 32'hCAFEF00D, 0, 32'h0, 32'h0, W);
        step();
        idle();
        flush();
        chk("after reset o_misaligned", {31'h0, bus.o_misaligned}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
